// File: rtl/fc_layer_sequencer.sv
// Fully connected layer sequencer: drives one MAC through out[r] = sum_c W[r][c]*feat[c],
// issuing row-major reads and streaming each finished row over a valid/ready handshake.
module fc_layer_sequencer #(
  parameter int BITWIDTH = 32,
  parameter int N_IN     = 10,
  parameter int N_OUT    = 10,
  localparam int CW = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [CW-1:0]       feat_addr,
  output logic [RW-1:0]       wgt_row,
  output logic [CW-1:0]       wgt_col,
  input  logic [BITWIDTH-1:0] feat_data,
  input  logic [BITWIDTH-1:0] wgt_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RW-1:0]       out_idx,
  output logic [BITWIDTH-1:0] out_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(N_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_OUT - 1);

  state_t              state_r;
  logic [CW-1:0]       col_r;
  logic [RW-1:0]       row_r;
  logic [BITWIDTH-1:0] acc_r;
  logic                rd_d_r;
  logic [BITWIDTH-1:0] prod_s;

  // Product truncated to BITWIDTH bits; operands arrive one cycle after the read strobe.
  assign prod_s    = feat_data * wgt_data;
  assign feat_addr = col_r;
  assign wgt_col   = col_r;
  assign wgt_row   = row_r;

  // Sequencer FSM with registered control and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      col_r     <= {CW{1'b0}};
      row_r     <= {RW{1'b0}};
      acc_r     <= {BITWIDTH{1'b0}};
      rd_d_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= {RW{1'b0}};
      out_data  <= {BITWIDTH{1'b0}};
    end else begin
      rd_d_r <= rd_en;
      done   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            row_r   <= {RW{1'b0}};
            col_r   <= {CW{1'b0}};
            acc_r   <= {BITWIDTH{1'b0}};
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (rd_d_r) begin
            acc_r <= acc_r + prod_s;
          end else begin
            acc_r <= acc_r;
          end
          if (col_r == COL_LAST) begin
            rd_en   <= 1'b0;
            state_r <= ST_DRAIN;
          end else begin
            col_r   <= col_r + CW'(1);
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // The last column's operands land here; fold them straight into the result.
          out_data  <= acc_r + prod_s;
          out_idx   <= row_r;
          out_valid <= 1'b1;
          state_r   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row_r == ROW_LAST) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              row_r   <= row_r + RW'(1);
              col_r   <= {CW{1'b0}};
              acc_r   <= {BITWIDTH{1'b0}};
              rd_en   <= 1'b1;
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_EMIT;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: behavioural matrix-vector model,
// 1-cycle-latency stores, read-order and handshake monitors, directed and random passes.
module tb_fc_layer_sequencer;

  localparam int BW = 32;
  localparam int NI = 10;
  localparam int NO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, rd_en, out_valid, out_ready;
  logic [3:0]    feat_addr, wgt_col, wgt_row, out_idx;
  logic [BW-1:0] feat_data, wgt_data, out_data;

  logic [BW-1:0] feat_m [NI];
  logic [BW-1:0] wgt_m  [NO][NI];
  logic [BW-1:0] exp_out[NO];

  int n_checks = 0;
  int n_errors = 0;
  int pass_hs, pass_rd, pass_done;
  int ready_mode = 0;
  int wait_cnt   = 0;
  logic          prev_wait = 1'b0;
  logic [BW-1:0] prev_data;
  logic [3:0]    prev_idx;

  fc_layer_sequencer #(.BITWIDTH(BW), .N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .feat_addr(feat_addr), .wgt_row(wgt_row), .wgt_col(wgt_col),
    .feat_data(feat_data), .wgt_data(wgt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feature and weight stores: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      feat_data <= feat_m[feat_addr];
      wgt_data  <= wgt_m[wgt_row][wgt_col];
    end
  end

  // Consumer readiness: always ready, 5-cycle stall per element, or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        1: begin
          if (out_valid && wait_cnt < 5) begin out_ready = 1'b0; wait_cnt++; end
          else if (out_valid) out_ready = 1'b1;
          else begin out_ready = 1'b0; wait_cnt = 0; end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitors: row-major read order, output stream, hold-while-stalled, done count.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        chk("rd_row", wgt_row, pass_rd / NI);
        chk("rd_col", feat_addr, pass_rd % NI);
        chk("rd_wcol", wgt_col, pass_rd % NI);
        pass_rd++;
      end
      if (prev_wait) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_idx", out_idx, prev_idx);
      end
      if (out_valid) chk("rd_in_emit", rd_en, 0);
      if (out_valid && out_ready) begin
        chk("out_idx", out_idx, pass_hs);
        chk("out_data", out_data, (pass_hs < NO) ? {32'd0, exp_out[pass_hs]} : 64'hBAD0_BAD0_BAD0_BAD0);
        pass_hs++;
      end
      if (done) pass_done++;
      prev_wait = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx  = out_idx;
    end else begin
      prev_wait = 1'b0;
    end
  end

  function automatic void compute_model();
    for (int r = 0; r < NO; r++) begin
      logic [BW-1:0] acc;
      acc = 32'd0;
      for (int c = 0; c < NI; c++) acc = acc + feat_m[c] * wgt_m[r][c];
      exp_out[r] = acc;
    end
  endfunction

  task automatic load(input int kind);
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NI; c++)
        case (kind)
          0: wgt_m[r][c] = (r == c) ? 32'd1 : 32'd0;
          1: wgt_m[r][c] = 32'd2;
          default: wgt_m[r][c] = $urandom;
        endcase
    for (int c = 0; c < NI; c++)
      case (kind)
        0: feat_m[c] = c;
        1: feat_m[c] = 32'hFFFF_FFFF;
        default: feat_m[c] = $urandom;
      endcase
    compute_model();
  endtask

  // exp_done: cycle (counting the one after the start-sampling edge as 1) where done must be high; 0 skips.
  task automatic run_pass(input int exp_done, input bit extra_starts, input int abort_row);
    int k;
    bit seen;
    pass_hs = 0; pass_rd = 0; pass_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 1; seen = 1'b0;
    while (!seen && k < 3000) begin
      if (abort_row >= 0 && rd_en && wgt_row == 4'(abort_row)) begin
        rst = 1'b1; #1;
        chk("rst_outputs", {busy, out_valid, rd_en, done}, 0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_no_done", pass_done, 0);
        return;
      end
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
        start = extra_starts && (k == 5 || k == 60);
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (exp_done > 0) chk("done_cycle", k, exp_done);
    repeat (4) @(posedge clk);
    #1;
    chk("hs_count", pass_hs, NO);
    chk("rd_count", pass_rd, NI * NO);
    chk("done_count", pass_done, 1);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    load(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, rd_en, out_valid, out_idx, out_data, feat_addr, wgt_row, wgt_col}, 0);
    rst = 1'b0;

    ready_mode = 0; load(0); run_pass(121, 1'b0, -1);
    ready_mode = 1; load(0); run_pass(171, 1'b0, -1);
    ready_mode = 0; load(1);
    chk("wrap_model", exp_out[0], 32'hFFFF_FFEC);
    run_pass(121, 1'b0, -1);
    load(2); run_pass(121, 1'b1, -1);
    load(0); run_pass(0, 1'b0, 4);
    run_pass(121, 1'b0, -1);
    ready_mode = 2;
    for (int i = 0; i < 3; i++) begin
      load(2); run_pass(0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
